mmio_periph: RTL

- Parametrised memory-mapped I/O block for the 16-bit pipelined core.
- Replaces the fixed HEX/LEDR/LEDG/KEY/SW address decode currently inlined in the core.
- Adds synchronised, debounced keys with sticky press capture, a synchronised switch register, and an optional prescaled interval timer.
- Sits beside MemArray on the data-memory bus. The core selects DOUT when IO_HIT=1.

---
 rtl/mmio_periph_pkg.sv | 28 ++
 rtl/mmio_periph_key_debounce.sv | 51 +++++
 rtl/mmio_periph.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mmio_periph_pkg.sv
// Shared constants for the memory-mapped I/O block: register offsets within
// the 32-byte window, TCTL bit positions and the unmapped-read pattern.
package mmio_periph_pkg;

    localparam int OFS_W = 5;

    localparam logic [OFS_W-1:0] OFS_TCNT   = 5'h00;
    localparam logic [OFS_W-1:0] OFS_TLIM   = 5'h02;
    localparam logic [OFS_W-1:0] OFS_TCTL   = 5'h04;
    localparam logic [OFS_W-1:0] OFS_KDATA  = 5'h10;
    localparam logic [OFS_W-1:0] OFS_SDATA  = 5'h12;
    localparam logic [OFS_W-1:0] OFS_KPRESS = 5'h14;
    localparam logic [OFS_W-1:0] OFS_HEX    = 5'h18;
    localparam logic [OFS_W-1:0] OFS_LEDR   = 5'h1A;
    localparam logic [OFS_W-1:0] OFS_LEDG   = 5'h1C;

    localparam int TCTL_RUN   = 0;
    localparam int TCTL_READY = 1;
    localparam int TCTL_OVR   = 2;

    localparam logic [15:0] UNMAPPED_RD = 16'hDEAD;

    // Registers are halfword-aligned; byte-address bit 0 never selects anything.
    function automatic logic [OFS_W-1:0] word_ofs(input logic [OFS_W-1:0] a);
        return {a[OFS_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/mmio_periph_key_debounce.sv
// key_debounce: one key bit through a 2-flop synchroniser, then accepted only
// after DEB_CYCLES consecutive cycles differing from the current debounced value.
module key_debounce
    import mmio_periph_pkg::*;
#(
    parameter int   DEB_CYCLES = 50000,
    parameter logic RST_VAL    = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ, accept;

    always_comb begin
        differ = (s2_q != deb_q);
        accept = differ && (cnt_q == CW'(DEB_CYCLES - 1));
        cnt_d  = '0;
        if (differ && !accept)
            cnt_d = cnt_q + CW'(1);
        deb_d  = accept ? s2_q : deb_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            deb_q <= RST_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= d_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o = deb_q;
    // Keys are active-low, so a press is the debounced value falling 1->0;
    // flagged in the same cycle the new value is committed.
    assign fall_o = accept && deb_q;

endmodule

// File: rtl/mmio_periph.sv
// mmio_periph: 32-byte I/O window with hex/LED outputs, synchronised switches,
// debounced keys with sticky press capture, and an interval timer built only when MMIO_TIMER_EN is defined.
module mmio_periph
    import mmio_periph_pkg::*;
#(
    parameter int               DBITS      = 16,
    parameter logic [DBITS-1:0] IO_BASE    = 16'hFFE0,
    parameter int               NKEYS      = 4,
    parameter int               NSW        = 10,
    parameter int               NHEX       = 4,
    parameter int               NLEDR      = 10,
    parameter int               NLEDG      = 8,
    parameter int               DEB_CYCLES = 50000,
    parameter int               TICK_DIV   = 50000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DBITS-1:0]   ADDR,
    input  logic               WE,
    input  logic [DBITS-1:0]   DIN,
    output logic [DBITS-1:0]   DOUT,
    output logic               IO_HIT,
    input  logic [NKEYS-1:0]   KEYS_IN,
    input  logic [NSW-1:0]     SW_IN,
    output logic [4*NHEX-1:0]  HEX_OUT,
    output logic [NLEDR-1:0]   LEDR_OUT,
    output logic [NLEDG-1:0]   LEDG_OUT
);

    logic [OFS_W-1:0]  ofs;
    logic              wr;
    logic [DBITS-1:0]  rdata;

    logic [4*NHEX-1:0] hex_q, hex_d;
    logic [NLEDR-1:0]  ledr_q, ledr_d;
    logic [NLEDG-1:0]  ledg_q, ledg_d;
    logic [NKEYS-1:0]  kpress_q, kpress_d;
    logic [NSW-1:0]    sw_s1_q, sw_s2_q;
    logic [NKEYS-1:0]  kdeb, kfall;

    logic unused_ok;
    assign unused_ok = ^{DIN, ADDR[0]};

    assign IO_HIT = (ADDR[DBITS-1:OFS_W] == IO_BASE[DBITS-1:OFS_W]);
    assign ofs    = word_ofs(ADDR[OFS_W-1:0]);
    assign wr     = WE && IO_HIT;

    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .RST_VAL    (1'b1)
        ) u_deb (
            .clk_i  (CLK),
            .rst_i  (RST),
            .d_i    (KEYS_IN[g]),
            .q_o    (kdeb[g]),
            .fall_o (kfall[g])
        );
    end

    always_comb begin
        hex_d    = hex_q;
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        kpress_d = kpress_q;
        if (wr) begin
            case (ofs)
                OFS_HEX:    hex_d    = DIN[4*NHEX-1:0];
                OFS_LEDR:   ledr_d   = DIN[NLEDR-1:0];
                OFS_LEDG:   ledg_d   = DIN[NLEDG-1:0];
                OFS_KPRESS: kpress_d = kpress_q & ~DIN[NKEYS-1:0];
                default: ;
            endcase
        end
        // A press landing in the same cycle as its W1C clear is kept.
        kpress_d = kpress_d | kfall;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hex_q    <= '0;
            ledr_q   <= '0;
            ledg_q   <= '0;
            kpress_q <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            kpress_q <= kpress_d;
            sw_s1_q  <= SW_IN;
            sw_s2_q  <= sw_s1_q;
        end
    end

`ifdef MMIO_TIMER_EN
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DBITS-1:0] tcnt_q, tcnt_d, tlim_q, tlim_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic             run_q, run_d, rdy_q, rdy_d, ovr_q, ovr_d;
    logic             tcnt_wr, tctl_wr, psc_wrap, tick, match, set_rdy;

    always_comb begin
        tcnt_wr  = wr && (ofs == OFS_TCNT);
        tctl_wr  = wr && (ofs == OFS_TCTL);
        psc_wrap = (psc_q == PW'(TICK_DIV - 1));
        // A TCNT load swallows any tick that would have landed on the same edge.
        tick     = run_q && psc_wrap && !tcnt_wr;
        match    = (tlim_q != '0) && (tcnt_q == tlim_q);
        set_rdy  = tick && match;

        psc_d = psc_q;
        if (tcnt_wr)
            psc_d = '0;
        else if (run_q)
            psc_d = psc_wrap ? '0 : psc_q + PW'(1);

        tcnt_d = tcnt_q;
        if (tcnt_wr)
            tcnt_d = DIN;
        else if (tick)
            tcnt_d = match ? '0 : tcnt_q + DBITS'(1);

        tlim_d = (wr && (ofs == OFS_TLIM)) ? DIN : tlim_q;
        run_d  = tctl_wr ? DIN[TCTL_RUN] : run_q;
        rdy_d  = set_rdy | (rdy_q & ~(tctl_wr & DIN[TCTL_READY]));
        ovr_d  = (set_rdy & rdy_q) | (ovr_q & ~(tctl_wr & DIN[TCTL_OVR]));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt_q <= '0;
            tlim_q <= '0;
            psc_q  <= '0;
            run_q  <= 1'b0;
            rdy_q  <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tlim_q <= tlim_d;
            psc_q  <= psc_d;
            run_q  <= run_d;
            rdy_q  <= rdy_d;
            ovr_q  <= ovr_d;
        end
    end
`endif

    always_comb begin
        rdata = DBITS'(UNMAPPED_RD);
        case (ofs)
`ifdef MMIO_TIMER_EN
            OFS_TCNT: rdata = tcnt_q;
            OFS_TLIM: rdata = tlim_q;
            OFS_TCTL: begin
                rdata = '0;
                rdata[TCTL_OVR:TCTL_RUN] = {ovr_q, rdy_q, run_q};
            end
`endif
            OFS_KDATA: begin
                rdata = '0;
                rdata[NKEYS-1:0] = kdeb;
            end
            OFS_SDATA: begin
                rdata = '0;
                rdata[NSW-1:0] = sw_s2_q;
            end
            OFS_KPRESS: begin
                rdata = '0;
                rdata[NKEYS-1:0] = kpress_q;
            end
            OFS_HEX: begin
                rdata = '0;
                rdata[4*NHEX-1:0] = hex_q;
            end
            OFS_LEDR: begin
                rdata = '0;
                rdata[NLEDR-1:0] = ledr_q;
            end
            OFS_LEDG: begin
                rdata = '0;
                rdata[NLEDG-1:0] = ledg_q;
            end
            default: ;
        endcase
    end

    assign DOUT     = IO_HIT ? rdata : '0;
    assign HEX_OUT  = hex_q;
    assign LEDR_OUT = ledr_q;
    assign LEDG_OUT = ledg_q;

endmodule
